// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and the data (load/store) side of the pipeline. Data requests win over
// fetch because they belong to the older instruction. One global stall
// freezes the pipeline until every request of the current pipeline cycle has
// been served. Byte lanes are big-endian: address offset 0 is bits 31:24.
//
// Memory handshake: m_req is registered and, once raised, m_we/m_be/m_addr/
// m_wdata stay stable until the cycle m_ack is seen high; m_rdata is valid
// in that same cycle. m_req drops the cycle after the ack. An ack seen while
// no access is outstanding (IDLE) is ignored.
module mem_port_arbiter #(
  parameter int LAT_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic             d_byte,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic [31:0]      d_rdata,
  output logic             stall,
  output logic             m_req,
  output logic             m_we,
  output logic [3:0]       m_be,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_ack,
  input  logic [31:0]      m_rdata,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_e;

  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic               m_req_q, m_req_d;
  logic               m_we_q, m_we_d;
  logic [3:0]         m_be_q, m_be_d;
  logic [31:0]        m_addr_q, m_addr_d;
  logic [31:0]        m_wdata_q, m_wdata_d;
  logic [31:0]        i_rdata_q, i_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               d_done_q, d_done_d;
  logic               i_done_q, i_done_d;
  logic               timeout_q, timeout_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               stall_raw;
  logic               d_pend;
  logic               i_pend;
  logic               d_done_set;
  logic               i_done_set;
  logic               d_byte_st;
  logic [LAT_W-1:0]   lat_next;

  // Pending requests of the current pipeline cycle and the global stall.
  always_comb begin
    d_pend    = d_req & ~d_done_q;
    i_pend    = i_req & ~i_done_q;
    stall_raw = d_pend | i_pend;
    stall     = stall_raw & ~reset;
    d_byte_st = d_we & d_byte;
    lat_next  = (lat_cnt_q == LAT_MAX) ? LAT_MAX : lat_cnt_q + 1'b1;
  end

  // Next-state logic: access sequencing, lane steering, done flags, watchdog.
  always_comb begin
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_be_d      = m_be_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    timeout_d   = timeout_q;
    lat_cnt_d   = lat_cnt_q;
    d_done_set  = 1'b0;
    i_done_set  = 1'b0;

    unique case (state_q)
      IDLE: begin
        lat_cnt_d = '0;
        if (d_pend) begin
          state_d   = D_ACC;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = {d_addr[31:2], 2'b00};
          m_be_d    = d_byte_st ? (4'b1000 >> d_addr[1:0]) : 4'b1111;
          m_wdata_d = d_byte_st ? {4{d_wdata[7:0]}} : d_wdata;
        end else if (i_pend) begin
          state_d  = I_ACC;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = {i_addr[31:2], 2'b00};
          m_be_d   = 4'b1111;
        end
      end
      D_ACC, I_ACC: begin
        if (m_ack) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          lat_cnt_d = '0;
          if (state_q == D_ACC) begin
            d_done_set = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end else begin
            i_done_set = 1'b1;
            i_rdata_d  = m_rdata;
          end
        end else begin
          // Watchdog only flags a slow memory; the access keeps waiting.
          lat_cnt_d = lat_next;
          if (lat_next == LAT_MAX) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase

    // An edge without stall means the pipeline advances and consumes this
    // cycle's requests, so the done flags start over for the next one.
    d_done_d = stall_raw ? (d_done_q | d_done_set) : 1'b0;
    i_done_d = stall_raw ? (i_done_q | i_done_set) : 1'b0;

    stall_cnt_d = (stall_raw && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1
                                                          : stall_cnt_q;
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_be_q      <= 4'b0000;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      timeout_q   <= 1'b0;
      lat_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_be_q      <= m_be_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      timeout_q   <= timeout_d;
      lat_cnt_q   <= lat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    m_req     = m_req_q;
    m_we      = m_we_q;
    m_be      = m_be_q;
    m_addr    = m_addr_q;
    m_wdata   = m_wdata_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    timeout   = timeout_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of pipeline cycles with
// hand-computed memory accesses and results, plus hand sequences for reset,
// slow memory and reset in the middle of an access.
module tb_mem_port_arbiter;

  localparam int LAT_W = 4;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             i_req = 1'b0;
  logic [31:0]      i_addr = '0;
  logic [31:0]      i_rdata;
  logic             d_req = 1'b0;
  logic             d_we = 1'b0;
  logic             d_byte = 1'b0;
  logic [31:0]      d_addr = '0;
  logic [31:0]      d_wdata = '0;
  logic [31:0]      d_rdata;
  logic             stall;
  logic             m_req;
  logic             m_we;
  logic [3:0]       m_be;
  logic [31:0]      m_addr;
  logic [31:0]      m_wdata;
  logic             m_ack = 1'b0;
  logic [31:0]      m_rdata = '0;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;

  mem_port_arbiter #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .stall(stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .timeout(timeout), .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_stall_cnt = '0;

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] mem_d;
    logic [31:0] mem_i;
    logic [31:0] exp_d_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_i_maddr;
    int          exp_stall;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_i_rdata;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver ----------------
  // One pipeline cycle: hold the requests while stalled, act as a memory
  // that acks in the first cycle m_req is seen, and check each access.
  task automatic run_vec(input int idx, input vec_t v);
    logic [68:0] exp_q[$];
    logic [31:0] rsp_q[$];
    logic [68:0] e;
    int          stall_cycles;
    if (v.d_req) begin
      exp_q.push_back({v.exp_d_maddr, v.exp_be, v.d_we, v.exp_wdata});
      rsp_q.push_back(v.mem_d);
    end
    if (v.i_req) begin
      exp_q.push_back({v.exp_i_maddr, 4'b1111, 1'b0, 32'h0});
      rsp_q.push_back(v.mem_i);
    end
    @(negedge clk);
    reset   = 1'b0;
    d_req   = v.d_req;
    d_we    = v.d_we;
    d_byte  = v.d_byte;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    i_req   = v.i_req;
    i_addr  = v.i_addr;
    stall_cycles = 0;
    for (int c = 0; c < 64; c++) begin
      m_ack = 1'b0;
      #1;
      if (!stall) break;
      stall_cycles++;
      if (m_req) begin
        if (exp_q.size() == 0) begin
          check32($sformatf("v%0d unexpected m_req", idx), 32'(m_req), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check32($sformatf("v%0d m_addr", idx), m_addr, e[68:37]);
          check32($sformatf("v%0d m_be", idx), 32'(m_be), 32'(e[36:33]));
          check32($sformatf("v%0d m_we", idx), 32'(m_we), 32'(e[32]));
          if (e[32]) check32($sformatf("v%0d m_wdata", idx), m_wdata, e[31:0]);
          m_rdata = rsp_q.pop_front();
          m_ack   = 1'b1;
        end
      end
      @(negedge clk);
    end
    exp_stall_cnt += CNT_W'(v.exp_stall);
    check32($sformatf("v%0d stall released", idx), 32'(stall), 32'h0);
    check32($sformatf("v%0d stall cycles", idx), stall_cycles, v.exp_stall);
    check32($sformatf("v%0d accesses left", idx), exp_q.size(), 0);
    check32($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_d_rdata);
    check32($sformatf("v%0d i_rdata", idx), i_rdata, v.exp_i_rdata);
    check32($sformatf("v%0d stall_cnt", idx), stall_cnt, exp_stall_cnt);
    check32($sformatf("v%0d m_req idle", idx), 32'(m_req), 32'h0);
    d_req = 1'b0;
    i_req = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    //        d_req d_we  d_byte d_addr        d_wdata       i_req i_addr
    //        mem_d         mem_i         d_maddr       be       wdata
    //        i_maddr       stall d_rdata       i_rdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40,
                32'h0, 32'h00A00093, 32'h0, 4'b1111, 32'h0,
                32'h40, 2, 32'h0, 32'h00A00093};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 32'h44,
                32'hDEADBEEF, 32'h11223344, 32'h104, 4'b1111, 32'h0,
                32'h44, 4, 32'hDEADBEEF, 32'h11223344};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h203, 32'h12345678, 1'b0, 32'h0,
                32'hCAFEF00D, 32'h0, 32'h200, 4'b0001, 32'h78787878,
                32'h0, 2, 32'hDEADBEEF, 32'h11223344};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h300, 32'hA5A50F0F, 1'b0, 32'h0,
                32'h0, 32'h0, 32'h300, 4'b1111, 32'hA5A50F0F,
                32'h0, 2, 32'hDEADBEEF, 32'h11223344};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h1000, 32'h000000AB, 1'b0, 32'h0,
                32'h0, 32'h0, 32'h1000, 4'b1000, 32'hABABABAB,
                32'h0, 2, 32'hDEADBEEF, 32'h11223344};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h1001, 32'hFFFFFF3C, 1'b1, 32'h4A,
                32'h0, 32'h55667788, 32'h1000, 4'b0100, 32'h3C3C3C3C,
                32'h48, 4, 32'hDEADBEEF, 32'h55667788};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h2002, 32'h0, 1'b0, 32'h0,
                32'h0BADF00D, 32'h0, 32'h2000, 4'b1111, 32'h0,
                32'h0, 2, 32'h0BADF00D, 32'h55667788};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                32'h0, 32'h0, 32'h0, 4'b0000, 32'h0,
                32'h0, 0, 32'h0BADF00D, 32'h55667788};

    // Reset held two cycles with a fetch pending.
    reset  = 1'b1;
    i_req  = 1'b1;
    i_addr = 32'h40;
    repeat (2) begin
      @(negedge clk);
      #1;
      check32("rst stall", 32'(stall), 32'h0);
      check32("rst m_req", 32'(m_req), 32'h0);
      check32("rst stall_cnt", stall_cnt, 32'h0);
    end
    check32("rst m_be", 32'(m_be), 32'h0);
    check32("rst m_addr", m_addr, 32'h0);
    check32("rst timeout", 32'(timeout), 32'h0);
    check32("rst i_rdata", i_rdata, 32'h0);
    check32("rst d_rdata", d_rdata, 32'h0);

    // Release reset into the first vector (single fetch), then the table.
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Slow memory: ack withheld for 20 cycles.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h500;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      check32($sformatf("slow m_req c%0d", k), 32'(m_req), 32'h1);
      check32($sformatf("slow m_addr c%0d", k), m_addr, 32'h500);
      check32($sformatf("slow m_be c%0d", k), 32'(m_be), 32'hF);
      check32($sformatf("slow stall c%0d", k), 32'(stall), 32'h1);
      check32($sformatf("slow timeout c%0d", k), 32'(timeout),
              (k >= 16) ? 32'h1 : 32'h0);
    end
    m_rdata = 32'h77778888;
    m_ack   = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    check32("slow stall done", 32'(stall), 32'h0);
    check32("slow d_rdata", d_rdata, 32'h77778888);
    check32("slow m_req drop", 32'(m_req), 32'h0);
    check32("slow timeout sticky", 32'(timeout), 32'h1);
    d_req = 1'b0;

    // Reset while a load is outstanding, with an ack in the same cycle.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h600;
    @(negedge clk);
    #1;
    check32("rma in access", 32'(m_req), 32'h1);
    reset   = 1'b1;
    m_ack   = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    #1;
    check32("rma stall in reset", 32'(stall), 32'h0);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    check32("rma m_req", 32'(m_req), 32'h0);
    check32("rma d_rdata", d_rdata, 32'h0);
    check32("rma timeout", 32'(timeout), 32'h0);
    // Release reset; an ack arriving while IDLE must be ignored.
    reset = 1'b0;
    m_ack = 1'b1;
    #1;
    check32("rma no done flag", 32'(stall), 32'h1);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    check32("rma reissue m_req", 32'(m_req), 32'h1);
    check32("rma reissue m_addr", m_addr, 32'h600);
    check32("rma idle ack ignored", d_rdata, 32'h0);
    m_rdata = 32'h13579BDF;
    m_ack   = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    check32("rma final stall", 32'(stall), 32'h0);
    check32("rma final d_rdata", d_rdata, 32'h13579BDF);
    check32("rma final m_req", 32'(m_req), 32'h0);
    d_req = 1'b0;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time limit: got no end expected end of test");
    $fatal(1, "time limit reached");
  end

endmodule
